// File: rtl/uart_io_pkg.sv
// rtl/uart_io_pkg.sv - shared types and default timing for the UART board I/O blocks
package uart_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } stretch_state_t;

  // Default timing assumes a 100 MHz system clock: 20 ms high, 20 ms gap.
  localparam int unsigned CLK_HZ             = 100_000_000;
  localparam int unsigned DEFAULT_ON_CYCLES  = 2_000_000;
  localparam int unsigned DEFAULT_OFF_CYCLES = 2_000_000;

  // Down-counter width able to hold the larger of the two reload values.
  function automatic int unsigned cnt_width(input int unsigned on_cycles,
                                            input int unsigned off_cycles);
    int unsigned m;
    m = (on_cycles > off_cycles) ? on_cycles : off_cycles;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pulse_stretch_if.sv
// rtl/pulse_stretch_if.sv - tick in / stretched pulse out bundle
interface pulse_stretch_if #(
  parameter int PEND_W = 4
);
  logic              tick;
  logic              led;
  logic              busy;
  logic              done_tick;
  logic [PEND_W-1:0] pend_cnt;

  // Event source and LED consumer side.
  modport master (output tick, input led, input busy, input done_tick, input pend_cnt);
  // Stretcher side.
  modport slave  (input tick, output led, output busy, output done_tick, output pend_cnt);
endinterface

// File: rtl/load_down_counter.sv
// rtl/load_down_counter.sv - loadable down-counter with zero flag, holds at zero
module load_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Load wins over decrement; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - stretches 1-cycle ticks into ON high / OFF low pulses; PULSE_STRETCH_PENDING_EN queues extra ticks
module pulse_stretch
  import uart_io_pkg::*;
#(
  parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
  parameter int OFF_CYCLES = DEFAULT_OFF_CYCLES,
  parameter int PEND_W     = 4
) (
  input logic            clk,
  input logic            reset,
  pulse_stretch_if.slave bus
);

  localparam int CW = cnt_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);

  stretch_state_t    state_q, state_d;
  logic              led_q, busy_q;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]     cnt_load_val, cnt;
  logic              last_gap, pend_avail, restart;
  logic [PEND_W-1:0] pend_q;

  load_down_counter #(.WIDTH(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  assign last_gap = (state_q == GAP) && cnt_zero;
  assign restart  = last_gap && (bus.tick || pend_avail);

`ifdef PULSE_STRETCH_PENDING_EN
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // Queue ticks seen while busy; a pending restart consumes one entry, and a
  // tick arriving in that same cycle takes its place in the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else if (last_gap && (pend_q != '0)) begin
      if (!bus.tick) pend_q <= pend_q - 1'b1;
    end else if ((state_q != IDLE) && !last_gap && bus.tick && (pend_q != PEND_MAX)) begin
      pend_q <= pend_q + 1'b1;
    end
  end

  assign pend_avail = (pend_q != '0);
`else
  assign pend_q     = '0;
  assign pend_avail = 1'b0;
`endif

  // State register; led and busy are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= (state_d == ON);
      busy_q  <= (state_d != IDLE);
    end
  end

  // Next state and counter reload/decrement control.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = ON_LOAD;
    cnt_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tick) begin
          state_d  = ON;
          cnt_load = 1'b1;
        end
      end
      ON: begin
        if (cnt_zero) begin
          state_d      = GAP;
          cnt_load     = 1'b1;
          cnt_load_val = OFF_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (cnt_zero) begin
          state_d  = restart ? ON : IDLE;
          cnt_load = restart;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: done_tick marks the last gap cycle of every pulse.
  always_comb begin
    bus.led       = led_q;
    bus.busy      = busy_q;
    bus.done_tick = last_gap;
    bus.pend_cnt  = pend_q;
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// tb/tb_pulse_stretch.sv - scoreboard bench for pulse_stretch (ON=4, OFF=3, PEND_W=2), honours PULSE_STRETCH_PENDING_EN
module tb_pulse_stretch;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;
`ifdef PULSE_STRETCH_PENDING_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  typedef struct packed {
    logic          led;
    logic          busy;
    logic          done;
    logic [PW-1:0] pend;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pulse_stretch_if #(.PEND_W(PW)) bus ();

  pulse_stretch #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .PEND_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  obs_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;

  // Reference model: one pulse occupies cycles start..start+ON+OFF-1.
  bit m_active = 1'b0;
  int m_start  = 0;
  int m_pend   = 0;

  function automatic obs_t model_expect(input int c);
    obs_t e;
    int   last;
    e    = '0;
    last = m_start + ON + OFF - 1;
    if (m_active) begin
      e.led  = (c >= m_start) && (c < m_start + ON);
      e.busy = 1'b1;
      e.done = (c == last);
    end
    e.pend = PW'(m_pend);
    return e;
  endfunction

  // Called just after a rising edge: record what the DUT must show this cycle,
  // then drive this cycle's inputs and advance the model past the next edge.
  task automatic step(input bit t, input bit r);
    int last;
    exp_q.push_back(model_expect(cyc));
    bus.tick = t;
    reset    = r;
    last     = m_start + ON + OFF - 1;
    if (r) begin
      m_active = 1'b0;
      m_pend   = 0;
    end else if (!m_active) begin
      if (t) begin
        m_active = 1'b1;
        m_start  = cyc + 1;
      end
    end else if (cyc == last) begin
      if (m_pend > 0) begin
        m_pend  = m_pend - 1;
        m_start = cyc + 1;
        if (t) m_pend = m_pend + 1;
      end else if (t) begin
        m_start = cyc + 1;
      end else begin
        m_active = 1'b0;
      end
    end else if (EN && t && m_pend < PMAX) begin
      m_pend = m_pend + 1;
    end
    cyc = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // Monitor: compare each cycle's outputs against the queued expectation.
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.led, bus.busy, bus.done_tick, bus.pend_cnt};
      total_cnt++;
      if (a === e) begin
        pass_cnt++;
      end else begin
        $display("FAIL outputs t=%0t: led=%b busy=%b done=%b pend=%0d, expected led=%b busy=%b done=%b pend=%0d",
                 $time, a.led, a.busy, a.done, a.pend, e.led, e.busy, e.done, e.pend);
      end
    end
  end

  initial begin
    int dens;
    reset    = 1'b1;
    bus.tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // single tick
    idle(3); step(1, 0); idle(12);
    // ticks at t, t+2, t+3
    step(1, 0); idle(1); step(1, 0); step(1, 0); idle(20);
    // six consecutive ticks: pending saturation
    repeat (6) step(1, 0);
    idle(30);
    // tick in the last gap cycle restarts with no idle cycle
    step(1, 0); idle(6); step(1, 0); idle(12);
    // reset with a coincident tick mid-pulse
    step(1, 0); idle(1); step(1, 1); idle(5);
    // tick every cycle for 21 cycles
    repeat (21) step(1, 0);
    idle(12);

    // random traffic with varying tick density and rare resets
    dens = 20;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: dens = 5;
          1: dens = 20;
          2: dens = 50;
          default: dens = 90;
        endcase
      end
      step($urandom_range(0, 99) < dens, $urandom_range(0, 299) == 0);
    end
    idle(2);

    @(negedge clk);
    #1;
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
